// File: rtl/vexriscv_bus_pkg.sv
// Shared types for the VexRiscv data-bus to block-RAM bridge: access sizes,
// bridge states and the byte-lane mask helper.
package vexriscv_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RMW_WAIT = 2'd2,
    RMW_WR   = 2'd3
  } state_e;

  // Lanes touched by an access of the given size at byte offset a.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size_e'(size))
      SZ_BYTE: m = 4'b0001 << a;
      SZ_HALF: m = 4'b0011 << a;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vexriscv_store_merge.sv
// Lane merge for sub-word stores: masked lanes come from the store data,
// the others keep the word read back from RAM.
module vexriscv_store_merge (
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [3:0]  mask,
  output logic [31:0] merged
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = mask[i] ? data[8*i +: 8] : word[8*i +: 8];
  end

endmodule

// File: rtl/vexriscv_dbus_ram_bridge.sv
// VexRiscv simple dbus (cmd/rsp) to single block-RAM port bridge with range and
// alignment checking and read-modify-write for byte/halfword stores.
module vexriscv_dbus_ram_bridge
  import vexriscv_bus_pkg::*;
#(
  parameter int          RAM_DEPTH   = 8192,
  parameter int          RAM_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int         AW          = $clog2(RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dbus_cmd_valid,
  output logic          dbus_cmd_ready,
  input  logic          dbus_cmd_wr,
  input  logic [31:0]   dbus_cmd_address,
  input  logic [31:0]   dbus_cmd_data,
  input  logic [1:0]    dbus_cmd_size,
  output logic          dbus_rsp_valid,
  output logic [31:0]   dbus_rsp_data,
  output logic          dbus_rsp_error,
  output logic          bus_fault,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  output logic          ram_regce,
  input  logic [31:0]   ram_dout,
  output state_e        dbg_state
);

  localparam logic [32:0] SPAN       = 33'(RAM_DEPTH) * 33'd4;
  localparam logic        WAIT_LAST  = (RAM_LATENCY == 2);
  localparam logic        USE_REGCE  = (RAM_LATENCY == 2);

  state_e        state_q, state_d;
  logic          wait_cnt;
  logic          wait_done;
  logic          rd_q;
  logic [31:0]   off;
  logic          range_bad, align_bad, cmd_fault;
  logic [AW-1:0] cmd_idx;
  logic          is_word;
  logic          idle_cmd;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_data;
  logic [3:0]    lat_mask;
  logic [31:0]   old_word;
  logic [31:0]   merged;

  assign off       = dbus_cmd_address - BASE_ADDR;
  assign range_bad = (dbus_cmd_address < BASE_ADDR) || ({1'b0, off} >= SPAN);
  assign cmd_fault = range_bad || align_bad;
  assign cmd_idx   = off[AW+1:2];
  assign is_word   = (dbus_cmd_size == SZ_WORD);

  always_comb begin
    case (dbus_cmd_size)
      SZ_BYTE: align_bad = 1'b0;
      SZ_HALF: align_bad = dbus_cmd_address[0];
      SZ_WORD: align_bad = (dbus_cmd_address[1:0] != 2'b00);
      default: align_bad = 1'b1;
    endcase
  end

  // Handshake: a command transfers in the cycle where dbus_cmd_valid and
  // dbus_cmd_ready are both high; ready is high only in IDLE outside reset, and
  // the command must be held stable until that cycle.
  assign dbus_cmd_ready = (state_q == IDLE) && !reset;
  assign idle_cmd       = dbus_cmd_valid && dbus_cmd_ready;
  assign wait_done      = (wait_cnt == WAIT_LAST);
  assign ram_regce      = USE_REGCE && rd_q;
  assign dbg_state      = state_q;

  vexriscv_store_merge u_merge (
    .word   (old_word),
    .data   (lat_data),
    .mask   (lat_mask),
    .merged (merged)
  );

  // RAM port is driven combinationally; reset blanks it so an RMW write is dropped.
  always_comb begin
    state_d  = state_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (dbus_cmd_valid && !cmd_fault) begin
            ram_en   = 1'b1;
            ram_addr = cmd_idx;
            if (dbus_cmd_wr && is_word) begin
              ram_we  = 1'b1;
              ram_din = dbus_cmd_data;
            end else if (dbus_cmd_wr) begin
              state_d = RMW_WAIT;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
        RD_WAIT:  if (wait_done) state_d = IDLE;
        RMW_WAIT: if (wait_done) state_d = RMW_WR;
        RMW_WR: begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = lat_addr;
          ram_din  = merged;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wait_cnt       <= 1'b0;
      rd_q           <= 1'b0;
      dbus_rsp_valid <= 1'b0;
      dbus_rsp_error <= 1'b0;
      dbus_rsp_data  <= '0;
      bus_fault      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_q           <= ram_en && !ram_we;
      dbus_rsp_valid <= 1'b0;
      dbus_rsp_error <= 1'b0;
      bus_fault      <= 1'b0;
      if ((state_q == RD_WAIT || state_q == RMW_WAIT) && !wait_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= 1'b0;
      end
      if (idle_cmd && cmd_fault) begin
        if (dbus_cmd_wr) begin
          bus_fault <= 1'b1;
        end else begin
          dbus_rsp_valid <= 1'b1;
          dbus_rsp_error <= 1'b1;
          dbus_rsp_data  <= '0;
        end
      end
      if (state_q == RD_WAIT && wait_done) begin
        dbus_rsp_valid <= 1'b1;
        dbus_rsp_data  <= ram_dout;
      end
    end
  end

  // Datapath holding registers need no reset; they are only read after being loaded.
  always_ff @(posedge clk) begin
    if (idle_cmd && !cmd_fault && dbus_cmd_wr) begin
      lat_addr <= cmd_idx;
      lat_data <= dbus_cmd_data;
      lat_mask <= byte_mask(dbus_cmd_size, dbus_cmd_address[1:0]);
    end
    if (state_q == RMW_WAIT && wait_done) begin
      old_word <= ram_dout;
    end
  end

endmodule
